// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter, LSB first, fed by a small valid/ready byte FIFO.
// Frames are sent back-to-back while the FIFO holds data.
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BAUD_PERIOD = 434,
    parameter int unsigned FIFO_DEPTH           = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_data_valid,
    input  logic [7:0]                    i_data_byte,
    output logic                          o_data_ready,
    output logic                          o_tx_data_line,
    output logic                          o_tx_busy,
    output logic                          o_tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BAUD_PERIOD);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BAUD_PERIOD - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START_BIT,
        S_DATA_BITS,
        S_STOP_BIT,
        S_CLEANUP
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    w_count_next;
    logic                w_push;
    logic                w_pop;
    logic [7:0]          r_shift;
    logic [BAUD_W-1:0]   r_baud;
    logic [BAUD_W-1:0]   w_baud_next;
    logic [2:0]          r_bit;
    logic [2:0]          w_bit_next;
    logic                w_line_next;
    logic                r_tx_line;
    logic                r_ready;
    logic                r_busy;
    logic                r_done;

    assign w_push       = i_data_valid && r_ready;
    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data_byte;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_shift   <= '0;
            r_baud    <= '0;
            r_bit     <= '0;
            r_tx_line <= 1'b1;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_baud    <= w_baud_next;
            r_bit     <= w_bit_next;
            r_count   <= w_count_next;
            r_ready   <= (w_count_next != CNT_FULL);
            r_tx_line <= w_line_next;
            r_busy    <= (r_state != S_IDLE);
            r_done    <= (r_state == S_CLEANUP);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_shift  <= r_mem[r_rd_ptr];
            end
        end
    end

    // Line level is decided from the current state and registered one cycle later.
    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit;
        w_pop        = 1'b0;
        w_line_next  = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop        = 1'b1;
                    w_baud_next  = '0;
                    w_bit_next   = '0;
                    w_state_next = S_START_BIT;
                end
            end
            S_START_BIT: begin
                w_line_next = 1'b0;
                if (r_baud == BAUD_LAST) begin
                    w_baud_next  = '0;
                    w_state_next = S_DATA_BITS;
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            S_DATA_BITS: begin
                w_line_next = r_shift[r_bit];
                if (r_baud == BAUD_LAST) begin
                    w_baud_next = '0;
                    if (r_bit == 3'd7) begin
                        w_state_next = S_STOP_BIT;
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            S_STOP_BIT: begin
                if (r_baud == BAUD_LAST) begin
                    w_baud_next  = '0;
                    w_state_next = S_CLEANUP;
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            S_CLEANUP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign o_data_ready   = r_ready;
    assign o_tx_data_line = r_tx_line;
    assign o_tx_busy      = r_busy;
    assign o_tx_done      = r_done;
    assign o_fifo_count   = r_count;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: accepted bytes are queued as expectations and a
// serial-line receiver model pops and compares each decoded frame.
module tb_uart_tx_fifo;

    localparam int unsigned CLKS  = 8;
    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic       ready;
    logic       line;
    logic       busy;
    logic       done;
    logic [2:0] count;

    uart_tx_fifo #(
        .CLKS_PER_BAUD_PERIOD (CLKS),
        .FIFO_DEPTH           (DEPTH)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_data_valid   (valid),
        .i_data_byte    (data),
        .o_data_ready   (ready),
        .o_tx_data_line (line),
        .o_tx_busy      (busy),
        .o_tx_done      (done),
        .o_fifo_count   (count)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         frames_rx = 0;
    int         frames_started = 0;
    int         done_cnt = 0;
    bit         mon_en = 1'b0;
    bit         rst_seen = 1'b0;
    bit         rx_active = 1'b0;
    bit         saw_full = 1'b0;
    logic       mon_prev = 1'b1;
    logic       rx_prev = 1'b1;
    logic       rx_st;
    logic       rx_sp;
    logic [7:0] rx_byte;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle invariants and event counters.
    always @(negedge clk) begin
        if (mon_en) begin
            check("ready_vs_count", {31'd0, ready}, {31'd0, (count != 3'd4)});
            if (done) done_cnt++;
            if (mon_prev && !line) frames_started++;
            mon_prev = line;
        end
    end

    // Receiver model: mid-bit sampling, then pop and compare against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && !rst && rx_prev && !line) begin
                rx_active = 1'b1;
                rst_seen  = 1'b0;
                repeat (3) @(negedge clk);
                rx_st = line;
                for (int i = 0; i < 8; i++) begin
                    repeat (CLKS) @(negedge clk);
                    rx_byte[i] = line;
                end
                repeat (CLKS) @(negedge clk);
                rx_sp = line;
                if (!rst_seen) begin
                    frames_rx++;
                    check("start_bit", {31'd0, rx_st}, 32'd0);
                    check("stop_bit", {31'd0, rx_sp}, 32'd1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_unexpected: got %0h expected no frame", rx_byte);
                    end else begin
                        check("rx_byte", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
                    end
                end
                rx_active = 1'b0;
            end
            rx_prev = line;
        end
    end

    // Holds valid high through the list; a byte counts as accepted when ready is high before the edge.
    task automatic send_seq(input logic [7:0] b [8], input int n);
        int         idx;
        int         guard;
        logic [2:0] cnt_before;
        idx   = 0;
        guard = 0;
        while (idx < n && guard < 2000) begin
            @(negedge clk);
            guard++;
            valid = 1'b1;
            data  = b[idx];
            if (ready) begin
                exp_q.push_back(b[idx]);
                @(posedge clk);
                idx++;
            end else begin
                saw_full   = 1'b1;
                cnt_before = count;
                @(posedge clk);
                #1;
                check("bp_no_write", {31'd0, (count <= cnt_before)}, 32'd1);
            end
        end
        @(negedge clk);
        valid = 1'b0;
        if (idx < n) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got %0d bytes accepted expected %0d", idx, n);
        end
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (!(exp_q.size() == 0 && !rx_active && !busy && count == 3'd0) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        repeat (4) @(negedge clk);
        check("drain_timeout", {31'd0, (guard < 5000)}, 32'd1);
    endtask

    logic [7:0] seq [8];
    logic [9:0] frame;
    int         f0;
    int         d0;
    int         guard;

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        data  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_line", {31'd0, line}, 32'd1);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_count", {29'd0, count}, 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Single byte 0xA5: latency and exact line waveform.
        @(negedge clk);
        valid = 1'b1;
        data  = 8'hA5;
        check("a5_ready", {31'd0, ready}, 32'd1);
        exp_q.push_back(8'hA5);
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        check("a5_count_after_push", {29'd0, count}, 32'd1);
        check("a5_line_n", {31'd0, line}, 32'd1);
        @(negedge clk);
        check("a5_line_n1", {31'd0, line}, 32'd1);
        check("a5_count_after_pop", {29'd0, count}, 32'd0);
        frame = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            check("a5_line", {31'd0, line}, {31'd0, frame[i / 8]});
        end
        @(negedge clk);
        check("a5_done_pulse", {31'd0, done}, 32'd1);
        @(negedge clk);
        check("a5_done_clear", {31'd0, done}, 32'd0);
        check("a5_busy_clear", {31'd0, busy}, 32'd0);
        wait_drain();
        check("a5_frames", frames_rx, 32'd1);
        check("a5_done_cnt", done_cnt, 32'd1);

        // Burst 0x01..0x06 with backpressure.
        f0  = frames_rx;
        d0  = done_cnt;
        seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00, 8'h00};
        send_seq(seq, 6);
        check("burst_saw_full", {31'd0, saw_full}, 32'd1);
        wait_drain();
        check("burst_frames", frames_rx - f0, 32'd6);
        check("burst_done_cnt", done_cnt - d0, 32'd6);
        check("burst_count", {29'd0, count}, 32'd0);

        // Loopback sequence.
        f0  = frames_rx;
        seq = '{8'h00, 8'hFF, 8'h55, 8'h3C, 8'h80, 8'h00, 8'h00, 8'h00};
        send_seq(seq, 5);
        wait_drain();
        check("loop_frames", frames_rx - f0, 32'd5);

        // Reset during data bit 3 with two bytes still queued.
        seq = '{8'h00, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_seq(seq, 3);
        guard = 0;
        while (line !== 1'b0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("rst_test_start_seen", {31'd0, (guard < 20)}, 32'd1);
        check("rst_test_queued", {29'd0, count}, 32'd2);
        repeat (35) @(negedge clk);
        check("rst_test_busy_before", {31'd0, busy}, 32'd1);
        check("rst_test_line_before", {31'd0, line}, 32'd0);
        rst      = 1'b1;
        rst_seen = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("midrst_line", {31'd0, line}, 32'd1);
        check("midrst_count", {29'd0, count}, 32'd0);
        check("midrst_ready", {31'd0, ready}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        f0  = frames_started;
        d0  = done_cnt;
        repeat (200) @(negedge clk);
        check("midrst_no_frame", frames_started - f0, 32'd0);
        check("midrst_no_done", done_cnt - d0, 32'd0);
        check("midrst_line_idle", {31'd0, line}, 32'd1);
        check("midrst_count_idle", {29'd0, count}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
